dds_sweep_ctrl: RTL and testbench

Sequencer that drives the frequency-tuning word, phase offset and waveform select of the DDS phase accumulator / waveform ROM datapath. It holds a sweep configuration loaded through a valid/ready write port. On command it steps the frequency word from a start value to a stop value at a programmable dwell rate, in single-shot, wrapping or triangle (up/down) mode. It sits between the system control logic and the DDS core, replacing that core's hard-wired freq_data, phase_data and mux inputs.

---
 rtl/dds_sweep_ctrl_if.sv | 31 +++
 rtl/dds_sweep_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_sweep_ctrl_if.sv
// Sweep configuration write port: a valid/ready handshake carrying one
// complete sweep setup (frequency limits, step, dwell, mode, waveform, phase).
interface dds_sweep_ctrl_if #(
    parameter int FW = 32,
    parameter int PW = 12,
    parameter int DW = 16
);
    logic          cfg_valid;
    logic          cfg_ready;
    logic [FW-1:0] cfg_start;
    logic [FW-1:0] cfg_stop;
    logic [FW-1:0] cfg_step;
    logic [DW-1:0] cfg_dwell;
    logic [1:0]    cfg_mode;
    logic [1:0]    cfg_wave;
    logic [PW-1:0] cfg_phase;

    // System control side: issues configuration writes
    modport master (
        output cfg_valid, cfg_start, cfg_stop, cfg_step, cfg_dwell,
               cfg_mode, cfg_wave, cfg_phase,
        input  cfg_ready
    );

    // Sweep controller side: accepts configuration writes
    modport slave (
        input  cfg_valid, cfg_start, cfg_stop, cfg_step, cfg_dwell,
               cfg_mode, cfg_wave, cfg_phase,
        output cfg_ready
    );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency sweep sequencer. Holds a shadow copy of the sweep setup and,
// on start, steps the DDS tuning word from start to stop, holding each value
// for a programmable number of clocks. Supports single-shot, wrapping and
// triangle sweeps; abort returns to idle holding the current tuning word.
module dds_sweep_ctrl #(
    parameter int FW = 32,
    parameter int PW = 12,
    parameter int DW = 16
) (
    input  logic                clk_50MHz,
    input  logic                rst,
    dds_sweep_ctrl_if.slave     cfg,
    input  logic                start,
    input  logic                abort,
    output logic [FW-1:0]       freq_word,
    output logic [PW-1:0]       phase_word,
    output logic [1:0]          wave_sel,
    output logic                busy,
    output logic                step_tick,
    output logic                sweep_done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_UP   = 2'd1,
        RUN_DOWN = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [1:0] MODE_WRAP     = 2'd1;
    localparam logic [1:0] MODE_TRIANGLE = 2'd2;

    state_t        state_q;

    // Shadow configuration, only written while idle
    logic [FW-1:0] start_q;
    logic [FW-1:0] stop_q;
    logic [FW-1:0] step_q;
    logic [DW-1:0] dwell_q;
    logic [1:0]    mode_q;
    logic [1:0]    wave_q;
    logic [PW-1:0] phase_q;

    // Registered DDS-facing outputs
    logic [FW-1:0] freq_q;
    logic [PW-1:0] phase_out_q;
    logic [1:0]    wave_out_q;
    logic          busy_q;
    logic          tick_q;
    logic          done_q;

    // Remaining cycles of the current dwell (0 = last cycle of the dwell)
    logic [DW-1:0] cnt_q;

    logic [DW-1:0] cnt_reload_d;
    logic [FW:0]   sum_up_d;
    logic [FW-1:0] diff_dn_d;
    logic [FW-1:0] up_next_d;
    logic [FW-1:0] dn_next_d;
    logic          at_end_up_d;
    logic          at_end_dn_d;
    logic          cfg_accept_d;

    assign cfg.cfg_ready = (state_q == IDLE);
    assign cfg_accept_d  = cfg.cfg_valid && (state_q == IDLE);

    // A dwell of 0 behaves as 1, so the reload value saturates at 0
    assign cnt_reload_d = (dwell_q == '0) ? '0 : dwell_q - DW'(1);

    // The up-step sum keeps the carry so an overflowing step clamps to stop
    assign sum_up_d  = {1'b0, freq_q} + {1'b0, step_q};
    assign diff_dn_d = freq_q - step_q;

    // Next value for each direction, clamped at the endpoint; a zero step
    // jumps straight to the endpoint so the sweep never stalls
    always_comb begin
        up_next_d = sum_up_d[FW-1:0];
        if (sum_up_d[FW] || (sum_up_d[FW-1:0] >= stop_q) || (step_q == '0)) begin
            up_next_d = stop_q;
        end
        dn_next_d = diff_dn_d;
        if ((freq_q < step_q) || (diff_dn_d <= start_q) || (step_q == '0)) begin
            dn_next_d = start_q;
        end
    end

    // Endpoint tests; a start at or above stop counts as already at the end
    assign at_end_up_d = (freq_q >= stop_q);
    assign at_end_dn_d = (freq_q <= start_q);

    // Sweep state machine with registered outputs and shadow config capture
    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            start_q     <= '0;
            stop_q      <= '0;
            step_q      <= '0;
            dwell_q     <= '0;
            mode_q      <= '0;
            wave_q      <= '0;
            phase_q     <= '0;
            freq_q      <= '0;
            phase_out_q <= '0;
            wave_out_q  <= '0;
            busy_q      <= 1'b0;
            tick_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            tick_q <= 1'b0;
            done_q <= 1'b0;

            if (cfg_accept_d) begin
                start_q <= cfg.cfg_start;
                stop_q  <= cfg.cfg_stop;
                step_q  <= cfg.cfg_step;
                dwell_q <= cfg.cfg_dwell;
                mode_q  <= cfg.cfg_mode;
                wave_q  <= cfg.cfg_wave;
                phase_q <= cfg.cfg_phase;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        freq_q      <= start_q;
                        phase_out_q <= phase_q;
                        wave_out_q  <= wave_q;
                        busy_q      <= 1'b1;
                        tick_q      <= 1'b1;
                        cnt_q       <= cnt_reload_d;
                        state_q     <= RUN_UP;
                    end
                end

                RUN_UP, RUN_DOWN: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - DW'(1);
                    end else begin
                        cnt_q <= cnt_reload_d;
                        if (state_q == RUN_UP) begin
                            if (!at_end_up_d) begin
                                freq_q <= up_next_d;
                                tick_q <= 1'b1;
                            end else if (mode_q == MODE_WRAP) begin
                                freq_q <= start_q;
                                tick_q <= 1'b1;
                            end else if (mode_q == MODE_TRIANGLE) begin
                                state_q <= RUN_DOWN;
                            end else begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end
                        end else begin
                            // Downward travel only happens in triangle mode
                            if (!at_end_dn_d) begin
                                freq_q <= dn_next_d;
                                tick_q <= 1'b1;
                            end else begin
                                state_q <= RUN_UP;
                            end
                        end
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign freq_word  = freq_q;
    assign phase_word = phase_out_q;
    assign wave_sel   = wave_out_q;
    assign busy       = busy_q;
    assign step_tick  = tick_q;
    assign sweep_done = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: stimulus pushes hand-computed
// per-cycle expectations tagged with their cycle number; a monitor samples
// the outputs on the falling edge and pops/compares entries as they fall due.
module tb_dds_sweep_ctrl;
    localparam int FW = 32;
    localparam int PW = 12;
    localparam int DW = 16;

    logic          clk_50MHz = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [FW-1:0] freq_word;
    logic [PW-1:0] phase_word;
    logic [1:0]    wave_sel;
    logic          busy;
    logic          step_tick;
    logic          sweep_done;

    dds_sweep_ctrl_if #(.FW(FW), .PW(PW), .DW(DW)) cfg_if ();

    dds_sweep_ctrl #(.FW(FW), .PW(PW), .DW(DW)) dut (
        .clk_50MHz  (clk_50MHz),
        .rst        (rst),
        .cfg        (cfg_if),
        .start      (start),
        .abort      (abort),
        .freq_word  (freq_word),
        .phase_word (phase_word),
        .wave_sel   (wave_sel),
        .busy       (busy),
        .step_tick  (step_tick),
        .sweep_done (sweep_done)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    typedef struct {
        int unsigned   at;
        string         tag;
        logic [FW-1:0] freq;
        logic [PW-1:0] phase;
        logic [1:0]    wave;
        logic          busy;
        logic          tick;
        logic          done;
        logic          rdy;
    } exp_t;

    exp_t          sb_q[$];
    int unsigned   cyc = 0;
    int unsigned   base = 0;
    int            compared = 0;
    int            mismatched = 0;
    string         cur_tag = "reset";
    logic [PW-1:0] exp_phase = '0;
    logic [1:0]    exp_wave = '0;

    always @(posedge clk_50MHz) cyc <= cyc + 1;

    // Monitor: compare every expectation whose cycle has arrived
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_50MHz);
            while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
                e = sb_q.pop_front();
                compared++;
                if (e.at != cyc || freq_word !== e.freq || phase_word !== e.phase ||
                    wave_sel !== e.wave || busy !== e.busy || step_tick !== e.tick ||
                    sweep_done !== e.done || cfg_if.cfg_ready !== e.rdy) begin
                    mismatched++;
                    $display("FAIL %s cyc=%0d(due %0d): got freq=%h phase=%h wave=%0d busy=%b tick=%b done=%b rdy=%b, expected freq=%h phase=%h wave=%0d busy=%b tick=%b done=%b rdy=%b",
                             e.tag, cyc, e.at, freq_word, phase_word, wave_sel, busy, step_tick,
                             sweep_done, cfg_if.cfg_ready, e.freq, e.phase, e.wave, e.busy,
                             e.tick, e.done, e.rdy);
                end else begin
                    $display("ok   %s cyc=%0d freq=%h phase=%h wave=%0d busy=%b tick=%b done=%b rdy=%b",
                             e.tag, cyc, freq_word, phase_word, wave_sel, busy, step_tick,
                             sweep_done, cfg_if.cfg_ready);
                end
            end
        end
    end

    task automatic push(input int k, input logic [FW-1:0] f, input logic b,
                        input logic t, input logic d);
        exp_t e;
        e.at    = base + k;
        e.tag   = cur_tag;
        e.freq  = f;
        e.phase = exp_phase;
        e.wave  = exp_wave;
        e.busy  = b;
        e.tick  = t;
        e.done  = d;
        e.rdy   = !b && !d;
        sb_q.push_back(e);
    endtask

    // One frequency point held for n cycles: tick on the first only
    task automatic hold(input int k0, input int n, input logic [FW-1:0] f);
        for (int i = 0; i < n; i++) push(k0 + i, f, 1'b1, (i == 0), 1'b0);
    endtask

    task automatic arm();
        @(negedge clk_50MHz);
        base = cyc;
    endtask

    task automatic wait_until(input int k);
        while (cyc < base + k) @(negedge clk_50MHz);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk_50MHz);
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(negedge clk_50MHz);
        abort = 1'b0;
    endtask

    task automatic cfg_write(input logic [FW-1:0] s, input logic [FW-1:0] p,
                             input logic [FW-1:0] st, input logic [DW-1:0] dw,
                             input logic [1:0] m, input logic [1:0] w,
                             input logic [PW-1:0] ph);
        int n;
        @(negedge clk_50MHz);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_start = s;
        cfg_if.cfg_stop  = p;
        cfg_if.cfg_step  = st;
        cfg_if.cfg_dwell = dw;
        cfg_if.cfg_mode  = m;
        cfg_if.cfg_wave  = w;
        cfg_if.cfg_phase = ph;
        n = 0;
        while (!cfg_if.cfg_ready && n < 20) begin
            @(negedge clk_50MHz);
            n++;
        end
        if (!cfg_if.cfg_ready) begin
            compared++;
            mismatched++;
            $display("FAIL cfg_write: cfg_ready=%b after %0d cycles, required 1", cfg_if.cfg_ready, n);
        end
        @(negedge clk_50MHz);
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, compared=%0d", compared);
        $fatal(1, "timeout");
    end

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_start = '0;
        cfg_if.cfg_stop  = '0;
        cfg_if.cfg_step  = '0;
        cfg_if.cfg_dwell = '0;
        cfg_if.cfg_mode  = '0;
        cfg_if.cfg_wave  = '0;
        cfg_if.cfg_phase = '0;

        // Reset state
        arm();
        push(1, '0, 1'b0, 1'b0, 1'b0);
        push(2, '0, 1'b0, 1'b0, 1'b0);
        wait_until(3);
        rst = 1'b1;

        // Single-shot, step 100, dwell 3
        cfg_write(1000, 1300, 100, 3, 2'd0, 2'd2, 12'h0FF);
        arm();
        cur_tag = "t1_step100"; exp_phase = 12'h0FF; exp_wave = 2'd2;
        hold(1, 3, 1000); hold(4, 3, 1100); hold(7, 3, 1200); hold(10, 3, 1300);
        push(13, 1300, 1'b0, 1'b0, 1'b1);
        push(14, 1300, 1'b0, 1'b0, 1'b0);
        pulse_start();
        wait_until(15);

        // Single-shot, step 250 clamps to stop
        cfg_write(1000, 1300, 250, 3, 2'd0, 2'd2, 12'h0FF);
        arm();
        cur_tag = "t2_clamp";
        hold(1, 3, 1000); hold(4, 3, 1250); hold(7, 3, 1300);
        push(10, 1300, 1'b0, 1'b0, 1'b1);
        push(11, 1300, 1'b0, 1'b0, 1'b0);
        pulse_start();
        wait_until(12);

        // Config write leaves outputs untouched
        cfg_write(0, 200, 100, 1, 2'd2, 2'd1, 12'h123);
        arm();
        cur_tag = "cfg_no_effect";
        push(1, 1300, 1'b0, 1'b0, 1'b0);
        wait_until(2);

        // Triangle sweep, writes blocked mid-sweep, abort on a step cycle
        arm();
        cur_tag = "t3_triangle"; exp_phase = 12'h123; exp_wave = 2'd1;
        hold(1, 1, 0); hold(2, 1, 100); hold(3, 2, 200);
        hold(5, 1, 100); hold(6, 2, 0); hold(8, 1, 100);
        push(9, 100, 1'b0, 1'b0, 1'b0);
        push(10, 100, 1'b0, 1'b0, 1'b0);
        pulse_start();
        wait_until(2);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_start = 5;
        cfg_if.cfg_stop  = 7;
        cfg_if.cfg_step  = 1;
        cfg_if.cfg_mode  = 2'd0;
        cfg_if.cfg_wave  = 2'd3;
        cfg_if.cfg_phase = 12'hEEE;
        wait_until(5);
        cfg_if.cfg_valid = 1'b0;
        wait_until(8);
        pulse_abort();
        wait_until(11);

        // Restart without rewriting: shadow must still hold the triangle setup
        arm();
        cur_tag = "t3_shadow_kept";
        hold(1, 1, 0); hold(2, 1, 100); hold(3, 2, 200);
        push(5, 200, 1'b0, 1'b0, 1'b0);
        pulse_start();
        wait_until(4);
        pulse_abort();
        wait_until(6);

        // Wrap mode with carry clamp at the top of the word range
        cfg_write(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 2, 2'd1, 2'd3, 12'hABC);
        arm();
        cur_tag = "t4_wrap_carry"; exp_phase = 12'hABC; exp_wave = 2'd3;
        hold(1, 2, 32'hFFFF_FF00); hold(3, 2, 32'hFFFF_FF80); hold(5, 2, 32'hFFFF_FFFF);
        hold(7, 2, 32'hFFFF_FF00); hold(9, 2, 32'hFFFF_FF80);
        push(11, 32'hFFFF_FF80, 1'b0, 1'b0, 1'b0);
        pulse_start();
        wait_until(10);
        pulse_abort();
        wait_until(12);

        // Dwell 0 acts as dwell 1; mode 3 behaves as single-shot
        cfg_write(10, 30, 10, 0, 2'd3, 2'd0, 12'h001);
        arm();
        cur_tag = "t5_dwell0"; exp_phase = 12'h001; exp_wave = 2'd0;
        hold(1, 1, 10); hold(2, 1, 20); hold(3, 1, 30);
        push(4, 30, 1'b0, 1'b0, 1'b1);
        push(5, 30, 1'b0, 1'b0, 1'b0);
        pulse_start();
        wait_until(6);

        // start >= stop: single-shot completes after the first dwell
        cfg_write(500, 400, 10, 2, 2'd0, 2'd1, 12'h010);
        arm();
        cur_tag = "t6_start_ge_stop"; exp_phase = 12'h010; exp_wave = 2'd1;
        hold(1, 2, 500);
        push(3, 500, 1'b0, 1'b0, 1'b1);
        push(4, 500, 1'b0, 1'b0, 1'b0);
        pulse_start();
        wait_until(5);

        // Reset mid-sweep clears outputs without waiting for a clock edge
        cfg_write(1000, 2000, 100, 5, 2'd0, 2'd2, 12'h3FF);
        arm();
        cur_tag = "t7_reset_mid"; exp_phase = 12'h3FF; exp_wave = 2'd2;
        hold(1, 2, 1000);
        exp_phase = '0; exp_wave = '0;
        push(3, '0, 1'b0, 1'b0, 1'b0);
        push(4, '0, 1'b0, 1'b0, 1'b0);
        pulse_start();
        wait_until(2);
        @(posedge clk_50MHz);
        #1 rst = 1'b0;
        wait_until(4);
        rst = 1'b1;

        // After reset the shadow config is zero: zero-length single-shot
        arm();
        cur_tag = "t7_after_reset";
        hold(1, 1, '0);
        push(2, '0, 1'b0, 1'b0, 1'b1);
        push(3, '0, 1'b0, 1'b0, 1'b0);
        pulse_start();
        wait_until(4);

        repeat (3) @(negedge clk_50MHz);
        if (sb_q.size() != 0) begin
            compared += sb_q.size();
            mismatched += sb_q.size();
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
